bus_packer: RTL and testbench
=============================

Name: bus_packer

Overview:
Parametrised sequential bit-packing block. It accepts narrow IN_W-bit fields over a valid/ready handshake and concatenates N_FIELDS of them into one OUT_W-bit word. The field order is selectable per word: LSB-first or MSB-first. A flush request emits a partially filled word, zero-filled and tagged with its field count. It sits between narrow producers and wide bus consumers, generalising fixed one-shot bus concatenation into a streaming, back-pressured packer.

Parameters:
IN_W, 3, width of one input field (>=1)
N_FIELDS, 3, fields per output word (>=2)
OUT_W, IN_W*N_FIELDS, derived output width; not overridable
CNT_W, $clog2(N_FIELDS+1), width of the field counter and out_fields

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_data  input  IN_W  field to pack
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
msb_first  input  1  order select, sampled with the first field of each word
flush  input  1  one-cycle request to emit the current partial word
out_data  output  OUT_W  packed word
out_fields  output  CNT_W  number of valid fields in out_data (1..N_FIELDS)
out_valid  output  1  out_data/out_fields valid
out_ready  input  1  consumer accepts the output word

Behaviour:
- Reset (synchronous, active-high): acc=0, count=0, order=0, flush_pend=0, out_data=0, out_fields=0, out_valid=0. Reset mid-word discards the partial word and any stalled output word.
- Accept: in_valid && in_ready at a rising edge.
- Field k (0-based arrival index) placement:
  - LSB-first: bits [k*IN_W +: IN_W].
  - MSB-first: bits [(N_FIELDS-1-k)*IN_W +: IN_W].
- Order latching:
  - msb_first is latched into order on the accept with count==0.
  - Changes to msb_first mid-word are ignored until the next word.
- Slot handling:
  - out_free = !out_valid || out_ready.
  - On accept with count < N_FIELDS-1: write the field into acc and increment count.
  - On accept with count == N_FIELDS-1: the completed word (acc plus the new field) loads the output register. Set out_fields=N_FIELDS, out_valid=1, acc=0, count=0.
  - This load requires out_free; in_ready enforces it.
- Output timing: latency is one cycle from the final accept to out_valid. Full throughput is one field per cycle with out_ready held high.
- in_ready = !flush_pend && !(count==N_FIELDS-1 && !out_free).
- Output handshake:
  - out_valid clears on out_ready, unless a new word loads in the same cycle; in that case it stays 1 with the new data.
  - out_data and out_fields stay stable while out_valid && !out_ready.
- Flush:
  - flush pulse with count==0 and no accept that cycle: ignored.
  - Otherwise flush sets flush_pend. A field accepted in the same cycle is included first.
  - If that field completes the word, it is emitted as a normal full word and flush_pend is not set.
  - While flush_pend=1 and out_free: load acc (unfilled fields zero), set out_fields=count and out_valid=1, then clear acc, count and flush_pend.
  - While flush_pend=1, in_ready=0.
  - A flush arriving while flush_pend=1 is absorbed, with no second word.
- Arithmetic:
  - count and out_fields are unsigned and never exceed N_FIELDS.
  - Zero-fill for unfilled fields is all-zero bits regardless of order.

Decomposition:
- Shared package bus_pkg holds:
  - function field_lsb(idx, order, n, w), returning the placement offset;
  - localparam helpers for OUT_W and CNT_W;
  - typedef enum logic {ORD_LSB, ORD_MSB} order_t.
- One sub-module is natural: bus_out_reg, the output holding register with the valid/ready logic and the out_free output. The packer instantiates it once.

Test Plan (IN_W=3, N_FIELDS=3):
- Reset then idle -> out_valid=0, out_data=0, out_fields=0, in_ready=1.
- LSB-first: 3'b111, 3'b101, 3'b011 on consecutive cycles, out_ready=1 -> one cycle after the third accept, out_data=9'h0EF, out_fields=3, one-cycle out_valid pulse.
- Same fields with msb_first=1 on the first field, and msb_first toggled mid-word -> out_data=9'h1EB.
- Flush after 3'b111, 3'b101:
  - LSB-first -> out_data=9'h02F, out_fields=2.
  - MSB-first -> out_data=9'h1E8, out_fields=2.
  - Next word starts at count 0.
- Back-pressure: out_ready=0 with one full word held, then 2 more fields sent -> in_ready drops at count==2 and the output is held stable. Raising out_ready -> the held word transfers and the third field is accepted in the same cycle, with no loss or duplication.
- Reset asserted with count=2 and a stalled output word -> next cycle out_valid=0, count=0. The next three fields produce a correct fresh word.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus packer: field ordering and placement math.
package bus_pkg;

  typedef enum logic {ORD_LSB, ORD_MSB} order_t;

  function automatic int unsigned out_width(input int unsigned in_w, input int unsigned n);
    return in_w * n;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bit offset of field idx within the packed word for the given order.
  function automatic int unsigned field_lsb(input int unsigned idx, input order_t order,
                                            input int unsigned n, input int unsigned w);
    return (order == ORD_MSB) ? (n - 1 - idx) * w : idx * w;
  endfunction

endpackage

// File: rtl/bus_packer_if.sv
// Narrow-in / wide-out streaming interface of the bus packer.
interface bus_packer_if #(
  parameter int unsigned IN_W     = 3,
  parameter int unsigned N_FIELDS = 3
);
  localparam int unsigned OUT_W = IN_W * N_FIELDS;
  localparam int unsigned CNT_W = $clog2(N_FIELDS + 1);

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             msb_first;
  logic             flush;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_fields;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, msb_first, flush, out_ready,
    input  in_ready, out_data, out_fields, out_valid
  );

  modport slave (
    input  in_data, in_valid, msb_first, flush, out_ready,
    output in_ready, out_data, out_fields, out_valid
  );
endinterface

// File: rtl/bus_out_reg.sv
// Output holding register: keeps a packed word stable until the consumer takes it.
module bus_out_reg #(
  parameter int unsigned OUT_W = 9,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic [CNT_W-1:0] fields_i,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic [CNT_W-1:0] out_fields_o,
  output logic             out_valid_o,
  output logic             out_free_o
);

  logic [OUT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] fields_q, fields_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      fields_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      data_q   <= data_d;
      fields_q <= fields_d;
      valid_q  <= valid_d;
    end
  end

  // A load wins over the drain so back-to-back words keep valid high.
  always_comb begin
    data_d   = data_q;
    fields_d = fields_q;
    valid_d  = valid_q;
    if (load_i) begin
      data_d   = data_i;
      fields_d = fields_i;
      valid_d  = 1'b1;
    end else if (out_ready_i) begin
      valid_d  = 1'b0;
    end
  end

  assign out_data_o   = data_q;
  assign out_fields_o = fields_q;
  assign out_valid_o  = valid_q;
  assign out_free_o   = !valid_q || out_ready_i;

endmodule

// File: rtl/bus_packer.sv
// Streaming packer: gathers N_FIELDS narrow fields into one wide word, LSB- or MSB-first,
// with a flush that emits a zero-filled partial word tagged by its field count.
module bus_packer
  import bus_pkg::*;
#(
  parameter int unsigned IN_W     = 3,
  parameter int unsigned N_FIELDS = 3
) (
  input logic         clk,
  input logic         reset,
  bus_packer_if.slave bus_io
);

  localparam int unsigned OUT_W = out_width(IN_W, N_FIELDS);
  localparam int unsigned CNT_W = cnt_width(N_FIELDS);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_FIELDS - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(N_FIELDS);

  typedef enum logic [0:0] {StFill, StFlush} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  order_t           order_q, order_d;

  logic             out_free;
  logic             in_ready;
  logic             accept;
  logic             is_last;
  logic             load;
  order_t           order_eff;
  logic [OUT_W-1:0] acc_ins;
  logic [OUT_W-1:0] load_data;
  logic [CNT_W-1:0] load_fields;

  assign is_last = (count_q == LastCnt);
  assign accept  = bus_io.in_valid && in_ready;

  // The order is taken live from msb_first on a word's first field, latched thereafter.
  assign order_eff = (count_q == '0) ? (bus_io.msb_first ? ORD_MSB : ORD_LSB) : order_q;
  assign acc_ins   = acc_q |
                     (OUT_W'(bus_io.in_data) << field_lsb(32'(count_q), order_eff,
                                                          N_FIELDS, IN_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFill;
      acc_q   <= '0;
      count_q <= '0;
      order_q <= ORD_LSB;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      order_q <= order_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    order_d = order_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (count_q == '0) order_d = order_eff;
          if (is_last) begin
            // Completed word goes straight to the output register; a same-cycle flush is moot.
            acc_d   = '0;
            count_d = '0;
          end else begin
            acc_d   = acc_ins;
            count_d = count_q + CNT_W'(1);
            if (bus_io.flush) state_d = StFlush;
          end
        end else if (bus_io.flush && (count_q != '0)) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (out_free) begin
          acc_d   = '0;
          count_d = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    load        = 1'b0;
    load_data   = acc_q;
    load_fields = count_q;
    unique case (state_q)
      StFill: begin
        in_ready    = !(is_last && !out_free);
        load        = bus_io.in_valid && in_ready && is_last;
        load_data   = acc_ins;
        load_fields = FullCnt;
      end
      StFlush: begin
        load = out_free;
      end
      default: ;
    endcase
  end

  assign bus_io.in_ready = in_ready;

  bus_out_reg #(
    .OUT_W(OUT_W),
    .CNT_W(CNT_W)
  ) u_out_reg (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .data_i       (load_data),
    .fields_i     (load_fields),
    .out_ready_i  (bus_io.out_ready),
    .out_data_o   (bus_io.out_data),
    .out_fields_o (bus_io.out_fields),
    .out_valid_o  (bus_io.out_valid),
    .out_free_o   (out_free)
  );

endmodule

// File: tb/tb_bus_packer.sv
// Scoreboard bench for bus_packer: directed fields in, expected words queued, monitor compares.
module tb_bus_packer;

  localparam int unsigned IN_W     = 3;
  localparam int unsigned N_FIELDS = 3;
  localparam int unsigned OUT_W    = 9;
  localparam int unsigned CNT_W    = 2;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] fields;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus_packer_if #(.IN_W(IN_W), .N_FIELDS(N_FIELDS)) bus ();

  bus_packer #(
    .IN_W     (IN_W),
    .N_FIELDS (N_FIELDS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_word(input logic [OUT_W-1:0] d, input logic [CNT_W-1:0] f);
    exp_t e;
    e.data   = d;
    e.fields = f;
    exp_q.push_back(e);
  endfunction

  // Monitor: a word transfers at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %0h/%0d expected none", bus.out_data, bus.out_fields);
      end else begin
        e = exp_q.pop_front();
        check("word_data", 32'(bus.out_data), 32'(e.data));
        check("word_fields", 32'(bus.out_fields), 32'(e.fields));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic m, input logic fl);
    int n = 0;
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.msb_first = m;
    bus.flush     = fl;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    cycles(1);
    bus.flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.msb_first = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    cycles(2);
    reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_fields", 32'(bus.out_fields), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    cycles(1);

    // LSB-first full word, one-cycle valid pulse
    expect_word(9'h0EF, 2'd3);
    send(3'b111, 1'b0, 1'b0);
    send(3'b101, 1'b0, 1'b0);
    send(3'b011, 1'b0, 1'b0);
    @(negedge clk);
    check("lsb_valid", 32'(bus.out_valid), 32'd1);
    check("lsb_data", 32'(bus.out_data), 32'h0EF);
    check("lsb_fields", 32'(bus.out_fields), 32'd3);
    cycles(1);
    @(negedge clk);
    check("lsb_pulse_end", 32'(bus.out_valid), 32'd0);
    cycles(1);

    // MSB-first with msb_first toggled mid-word
    expect_word(9'h1EB, 2'd3);
    send(3'b111, 1'b1, 1'b0);
    send(3'b101, 1'b0, 1'b0);
    send(3'b011, 1'b1, 1'b0);
    cycles(2);

    // Flush partial words
    expect_word(9'h02F, 2'd2);
    send(3'b111, 1'b0, 1'b0);
    send(3'b101, 1'b0, 1'b0);
    flush_pulse();
    @(negedge clk);
    check("flush_pend_in_ready", 32'(bus.in_ready), 32'd0);
    cycles(3);
    expect_word(9'h1E8, 2'd2);
    send(3'b111, 1'b1, 1'b0);
    send(3'b101, 1'b1, 1'b0);
    flush_pulse();
    cycles(3);
    expect_word(9'h0D1, 2'd3);
    send(3'b001, 1'b0, 1'b0);
    send(3'b010, 1'b0, 1'b0);
    send(3'b011, 1'b0, 1'b0);
    cycles(2);

    // Idle flush is ignored
    flush_pulse();
    @(negedge clk);
    check("idle_flush_in_ready", 32'(bus.in_ready), 32'd1);
    cycles(3);

    // Flush with a same-cycle field, and flush on a completing field
    expect_word(9'h006, 2'd1);
    send(3'b110, 1'b0, 1'b1);
    cycles(3);
    expect_word(9'h180, 2'd1);
    send(3'b110, 1'b1, 1'b1);
    cycles(3);
    expect_word(9'h0EF, 2'd3);
    send(3'b111, 1'b0, 1'b0);
    send(3'b101, 1'b0, 1'b0);
    send(3'b011, 1'b0, 1'b1);
    cycles(3);

    // Back-pressure: held word, in_ready drops on the last field slot
    bus.out_ready = 1'b0;
    expect_word(9'h0EF, 2'd3);
    send(3'b111, 1'b0, 1'b0);
    send(3'b101, 1'b0, 1'b0);
    send(3'b011, 1'b0, 1'b0);
    send(3'b001, 1'b0, 1'b0);
    send(3'b010, 1'b0, 1'b0);
    bus.in_data  = 3'b100;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_valid_held", 32'(bus.out_valid), 32'd1);
      check("bp_data_held", 32'(bus.out_data), 32'h0EF);
      cycles(1);
    end
    bus.out_ready = 1'b1;
    expect_word(9'h111, 2'd3);
    send(3'b100, 1'b0, 1'b0);
    cycles(3);

    // Second flush while one is pending is absorbed
    bus.out_ready = 1'b0;
    expect_word(9'h0EF, 2'd3);
    send(3'b111, 1'b0, 1'b0);
    send(3'b101, 1'b0, 1'b0);
    send(3'b011, 1'b0, 1'b0);
    send(3'b110, 1'b0, 1'b1);
    flush_pulse();
    @(negedge clk);
    check("absorb_in_ready", 32'(bus.in_ready), 32'd0);
    check("absorb_data_held", 32'(bus.out_data), 32'h0EF);
    cycles(1);
    expect_word(9'h006, 2'd1);
    bus.out_ready = 1'b1;
    cycles(4);

    // Reset with a stalled word and two fields pending
    bus.out_ready = 1'b0;
    send(3'b111, 1'b0, 1'b0);
    send(3'b101, 1'b0, 1'b0);
    send(3'b011, 1'b0, 1'b0);
    send(3'b001, 1'b0, 1'b0);
    send(3'b010, 1'b0, 1'b0);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_fields", 32'(bus.out_fields), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    cycles(1);
    bus.out_ready = 1'b1;
    expect_word(9'h163, 2'd3);
    send(3'b011, 1'b0, 1'b0);
    send(3'b100, 1'b0, 1'b0);
    send(3'b101, 1'b0, 1'b0);
    cycles(4);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
